// File: rtl/lab2_proc_imul_pkg.sv
// Shared encodings for the iterative integer multiply unit: RV32M multiply
// function codes and the control FSM state type.
package lab2_proc_imul_pkg;

    localparam logic [1:0] IMUL_FN_MUL    = 2'd0;
    localparam logic [1:0] IMUL_FN_MULH   = 2'd1;
    localparam logic [1:0] IMUL_FN_MULHSU = 2'd2;
    localparam logic [1:0] IMUL_FN_MULHU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } imul_state_e;

endpackage

// File: rtl/lab2_proc_imul_var_dpath.sv
// Shift-add datapath for the multiply unit: operand magnitudes, accumulator,
// iteration counter and final sign fix-up. LAB2_PROC_IMUL_EARLY_TERM_EN stops early once b is spent.
module lab2_proc_imul_var_dpath
    import lab2_proc_imul_pkg::*;
#(
    parameter int unsigned p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld,
    input  logic               step,
    input  logic               out_en,
    input  logic [1:0]         fn,
    input  logic [p_nbits-1:0] a,
    input  logic [p_nbits-1:0] b,
    output logic               last,
    output logic [p_nbits-1:0] result
);

    localparam int unsigned CW = $clog2(p_nbits) + 1;

    logic [2*p_nbits-1:0] a_reg;
    logic [2*p_nbits-1:0] acc;
    logic [p_nbits-1:0]   b_reg;
    logic [CW-1:0]        count;
    logic [1:0]           fn_reg;
    logic                 neg_reg;

    logic                 sign_a;
    logic                 sign_b;
    logic [p_nbits-1:0]   a_mag;
    logic [p_nbits-1:0]   b_mag;
    logic                 b_zero;
    logic                 count_last;
    logic                 upd;
    logic [2*p_nbits-1:0] prod;

    always_comb begin
        sign_a = ((fn == IMUL_FN_MULH) || (fn == IMUL_FN_MULHSU)) && a[p_nbits-1];
        sign_b = (fn == IMUL_FN_MULH) && b[p_nbits-1];
        // The negated most-negative value is still correct as an unsigned magnitude.
        a_mag  = sign_a ? (~a + 1'b1) : a;
        b_mag  = sign_b ? (~b + 1'b1) : b;
    end

    assign b_zero     = (b_reg == '0);
    assign count_last = (count == CW'(p_nbits - 1));

`ifdef LAB2_PROC_IMUL_EARLY_TERM_EN
    assign last = count_last || b_zero;
    assign upd  = step && !b_zero;
`else
    assign last = count_last;
    assign upd  = step;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_reg   <= '0;
            acc     <= '0;
            b_reg   <= '0;
            count   <= '0;
            fn_reg  <= IMUL_FN_MUL;
            neg_reg <= 1'b0;
        end else if (ld) begin
            a_reg   <= {{p_nbits{1'b0}}, a_mag};
            acc     <= '0;
            b_reg   <= b_mag;
            count   <= '0;
            fn_reg  <= fn;
            neg_reg <= sign_a ^ sign_b;
        end else if (upd) begin
            if (b_reg[0]) begin
                acc <= acc + a_reg;
            end
            a_reg <= a_reg << 1;
            b_reg <= b_reg >> 1;
            count <= count + CW'(1);
        end
    end

    always_comb begin
        prod   = neg_reg ? (~acc + 1'b1) : acc;
        result = '0;
        if (out_en) begin
            result = (fn_reg == IMUL_FN_MUL) ? prod[p_nbits-1:0] : prod[2*p_nbits-1:p_nbits];
        end
    end

endmodule

// File: rtl/lab2_proc_imul_var_unit.sv
// Iterative val/rdy integer multiply unit for the X stage (MUL/MULH/MULHSU/MULHU).
// Holds the control FSM; LAB2_PROC_IMUL_EARLY_TERM_EN enables early termination in the dpath.
module lab2_proc_imul_var_unit
    import lab2_proc_imul_pkg::*;
#(
    parameter int unsigned p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [1:0]         req_fn,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_result
);

    imul_state_e state_q;
    imul_state_e state_d;
    logic        init_q;
    logic        ld;
    logic        step;
    logic        last;

    // Keeps req_rdy low while reset is held and until the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_rdy  = 1'b0;
        resp_val = 1'b0;
        ld       = 1'b0;
        step     = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_rdy = init_q;
                if (req_val && init_q) begin
                    ld      = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    lab2_proc_imul_var_dpath #(
        .p_nbits(p_nbits)
    ) u_dpath (
        .clk   (clk),
        .reset (reset),
        .ld    (ld),
        .step  (step),
        .out_en(resp_val),
        .fn    (req_fn),
        .a     (req_a),
        .b     (req_b),
        .last  (last),
        .result(resp_result)
    );

endmodule

// File: tb/tb_lab2_proc_imul_var_unit.sv
// Self-checking bench: 32-bit and 8-bit multiply units against an arithmetic reference model.
module tb_lab2_proc_imul_var_unit;

    localparam int unsigned N  = 32;
    localparam int unsigned N8 = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_val;
    logic          req_rdy;
    logic [1:0]    req_fn;
    logic [N-1:0]  req_a;
    logic [N-1:0]  req_b;
    logic          resp_val;
    logic          resp_rdy;
    logic [N-1:0]  resp_result;

    logic          r8_req_val;
    logic          r8_req_rdy;
    logic [1:0]    r8_req_fn;
    logic [N8-1:0] r8_req_a;
    logic [N8-1:0] r8_req_b;
    logic          r8_resp_val;
    logic          r8_resp_rdy;
    logic [N8-1:0] r8_resp_result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lab2_proc_imul_var_unit #(.p_nbits(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_val    (req_val),
        .req_rdy    (req_rdy),
        .req_fn     (req_fn),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_val   (resp_val),
        .resp_rdy   (resp_rdy),
        .resp_result(resp_result)
    );

    lab2_proc_imul_var_unit #(.p_nbits(N8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .req_val    (r8_req_val),
        .req_rdy    (r8_req_rdy),
        .req_fn     (r8_req_fn),
        .req_a      (r8_req_a),
        .req_b      (r8_req_b),
        .resp_val   (r8_resp_val),
        .resp_rdy   (r8_resp_rdy),
        .resp_result(r8_resp_result)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask_n(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic logic [63:0] ext(input logic [63:0] v, input int n, input bit sgn);
        logic [63:0] r;
        r = v & mask_n(n);
        if (sgn && r[n-1]) r = r | ~mask_n(n);
        return r;
    endfunction

    // Product of the operands interpreted per fn, taken modulo 2^64 then word-selected.
    function automatic logic [63:0] ref_mul(input int n, input logic [1:0] fn,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] p;
        p = ext(a, n, (fn == 2'd1) || (fn == 2'd2)) * ext(b, n, fn == 2'd1);
        return (fn == 2'd0) ? (p & mask_n(n)) : ((p >> n) & mask_n(n));
    endfunction

    function automatic int ref_calc_cycles(input int n, input logic [1:0] fn, input logic [63:0] b);
`ifdef LAB2_PROC_IMUL_EARLY_TERM_EN
        logic [63:0] m;
        int hi;
        m  = b & mask_n(n);
        hi = -1;
        if (fn == 2'd1 && m[n-1]) m = (~m + 64'd1) & mask_n(n);
        for (int i = 0; i < n; i++) if (m[i]) hi = i;
        if (hi < 0) return 1;
        return (hi + 2 > n) ? n : hi + 2;
`else
        return n;
`endif
    endfunction

    function automatic logic [31:0] pick32();
        logic [31:0] specials [4];
        specials[0] = 32'h0;
        specials[1] = 32'h1;
        specials[2] = 32'h8000_0000;
        specials[3] = 32'hFFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    // One full transaction on the 32-bit unit; latency counts the accept edge as cycle 1.
    task automatic run_op(input logic [1:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [63:0] exp_r;
        int          exp_lat;
        int          lat;
        bit          seen;
        exp_r   = ref_mul(N, fn, {32'h0, a}, {32'h0, b});
        exp_lat = ref_calc_cycles(N, fn, {32'h0, b}) + 1;
        lat = 0;
        while (!req_rdy && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("req_rdy_idle", req_rdy, 1);
        req_val  = 1'b1;
        req_fn   = fn;
        req_a    = a;
        req_b    = b;
        resp_rdy = 1'b0;
        @(posedge clk); #1;
        // Garbage with req_val still high must be ignored while busy.
        req_fn = 2'($urandom);
        req_a  = $urandom;
        req_b  = $urandom;
        check_eq("calc_result_zero", resp_result, 0);
        check_eq("calc_req_rdy", req_rdy, 0);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < N + 10) begin
            @(posedge clk); #1;
            lat++;
            seen = resp_val;
        end
        req_val = 1'b0;
        check_eq("resp_val", seen, 1);
        check_eq("latency", lat, exp_lat);
        check_eq("result", resp_result, exp_r);
        check_eq("done_req_rdy", req_rdy, 0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check_eq("hold_val", resp_val, 1);
            check_eq("hold_result", resp_result, exp_r);
            check_eq("hold_req_rdy", req_rdy, 0);
        end
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        check_eq("post_resp_val", resp_val, 0);
        check_eq("post_req_rdy", req_rdy, 1);
        check_eq("post_result", resp_result, 0);
    endtask

    task automatic run8(input logic [1:0] fn, input logic [7:0] a, input logic [7:0] b);
        logic [63:0] exp_r;
        int          lat;
        bit          seen;
        exp_r = ref_mul(N8, fn, {56'h0, a}, {56'h0, b});
        check_eq("r8_req_rdy", r8_req_rdy, 1);
        r8_req_val = 1'b1;
        r8_req_fn  = fn;
        r8_req_a   = a;
        r8_req_b   = b;
        @(posedge clk); #1;
        r8_req_val = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < N8 + 10) begin
            @(posedge clk); #1;
            lat++;
            seen = r8_resp_val;
        end
        check_eq("r8_resp_val", seen, 1);
        check_eq("r8_latency", lat, ref_calc_cycles(N8, fn, {56'h0, b}) + 1);
        check_eq("r8_result", r8_resp_result, exp_r);
        r8_resp_rdy = 1'b1;
        @(posedge clk); #1;
        r8_resp_rdy = 1'b0;
        check_eq("r8_post_val", r8_resp_val, 0);
    endtask

    initial begin
        reset       = 1'b0;
        req_val     = 1'b0;
        req_fn      = 2'd0;
        req_a       = '0;
        req_b       = '0;
        resp_rdy    = 1'b0;
        r8_req_val  = 1'b0;
        r8_req_fn   = 2'd0;
        r8_req_a    = '0;
        r8_req_b    = '0;
        r8_resp_rdy = 1'b0;
        #1;
        check_eq("reset_req_rdy", req_rdy, 0);
        check_eq("reset_resp_val", resp_val, 0);
        check_eq("reset_result", resp_result, 0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_held_req_rdy", req_rdy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("release_req_rdy", req_rdy, 1);
        check_eq("release_r8_req_rdy", r8_req_rdy, 1);

        run_op(2'd0, 32'd3, 32'd4, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd0, 32'd7, 32'd5, 5);

        // Reset in the middle of a calculation.
        req_val = 1'b1;
        req_fn  = 2'd0;
        req_a   = $urandom;
        req_b   = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        req_val = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("midreset_resp_val", resp_val, 0);
        check_eq("midreset_result", resp_result, 0);
        check_eq("midreset_req_rdy", req_rdy, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_eq("midreset_release_rdy", req_rdy, 1);
        check_eq("midreset_release_val", resp_val, 0);
        run_op(2'd0, 32'd2, 32'd2, 0);

        run_op(2'd0, 32'd6, 32'd0, 0);
        run_op(2'd0, 32'd6, 32'd1, 0);
        run8(2'd3, 8'hFF, 8'hFF);

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pick32(), pick32(), $urandom_range(0, 2));
        end
        for (int i = 0; i < 30; i++) begin
            run8(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab2_proc_imul_var_unit.md
Name: lab2_proc_imul_var_unit

Overview:
- Iterative, latency-insensitive integer multiply unit for the X stage of the pipelined processor.
- Feeds the third input of the X-stage result-select mux, the slot currently reserved for MUL.
- Generalises a fixed 32-bit low-word multiplier in two ways: width is parametrised (p_nbits), and all four RV32M multiply modes are supported (MUL, MULH, MULHSU, MULHU).
- Uses val/rdy handshakes on both sides so the pipeline control can stall X while a multiply is in flight.

Parameters:
- p_nbits, 32, operand and result width; 2*p_nbits accumulator; must be >= 4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_val  in  1  request valid.
- req_rdy  out  1  unit can accept a request.
- req_fn  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU.
- req_a  in  p_nbits  operand a (rs1).
- req_b  in  p_nbits  operand b (rs2).
- resp_val  out  1  result valid.
- resp_rdy  in  1  consumer accepts result.
- resp_result  out  p_nbits  product word selected by fn.

Behaviour:
- FSM states:
  - IDLE: req_rdy=1; req_val & req_rdy latches operands and fn, then goes to CALC.
  - CALC: shift-add, one multiplier bit per cycle.
  - DONE: resp_val=1, result held stable until resp_val & resp_rdy, then back to IDLE.
- IDLE never returns directly to DONE; there is no request/response overlap (req_rdy=0 in CALC and DONE).
- Sign handling at accept:
  - sign_a = a[msb] for MULH and MULHSU, else 0.
  - sign_b = b[msb] for MULH only.
  - Registers hold magnitudes |a|, |b| (two's-complement negate when the sign is set).
  - neg = sign_a ^ sign_b.
- |most-negative| = 2^(p_nbits-1) fits unsigned in p_nbits bits; no overflow special case.
- Datapath registers:
  - a_reg (2*p_nbits, zero-extended magnitude).
  - b_reg (p_nbits).
  - acc (2*p_nbits, cleared at accept).
  - count (clog2(p_nbits)+1 bits, cleared at accept).
- Each CALC cycle:
  - if b_reg[0], acc += a_reg.
  - a_reg <<= 1, b_reg >>= 1, count++.
  - Leave CALC after the cycle in which count reaches p_nbits-1, i.e. exactly p_nbits CALC cycles.
- Latency: request accepted at edge t -> resp_val high in cycle t+p_nbits+1 (33 cycles for default).
- Result, combinational from registered state in DONE:
  - prod = neg ? -acc : acc (2*p_nbits two's complement).
  - MUL returns prod[p_nbits-1:0]; the others return prod[2*p_nbits-1:p_nbits].
- resp_result is 0 outside DONE.
- Back-to-back: a response handshake in DONE moves to IDLE; a new request is accepted no earlier than the following cycle.
- Reset (any state, including mid-CALC):
  - Immediately: state=IDLE, acc/a_reg/b_reg/count=0, resp_val=0, resp_result=0.
  - req_rdy=0 while reset is low, 1 from the first edge after release.
  - The in-flight operation is discarded.
- req_val high with X operands in CALC/DONE has no effect.
- resp_rdy outside DONE is ignored.

Optional Feature:
- Macro: LAB2_PROC_IMUL_EARLY_TERM_EN.
- Defined:
  - CALC leaves to DONE at the start of any cycle where b_reg==0, without updating acc.
  - Latency becomes (index of highest set bit of |b|)+2 CALC cycles; |b|=0 gives 1 CALC cycle.
  - Still capped at p_nbits CALC cycles.
- Undefined: fixed p_nbits CALC cycles as above.
- Results are identical either way.

Decomposition:
- Shared package lab2_proc_imul_pkg:
  - fn encodings (IMUL_FN_MUL/MULH/MULHSU/MULHU).
  - FSM state enum (IDLE/CALC/DONE).
- One sub-module, lab2_proc_imul_var_dpath: magnitude conversion, shift/add registers, counter, final negate/word select.
- The top holds the FSM and handshakes, and drives control signals into the dpath.

Test Plan:
- MUL a=3, b=4, resp_rdy=1 -> resp_result=12; resp_val exactly 33 cycles after accept (macro off).
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- MUL 7x5 with resp_rdy low 5 cycles after resp_val -> resp_result holds 35, req_rdy stays 0, handshake on 6th cycle, then IDLE with req_rdy=1.
- Assert reset 10 cycles into a CALC -> resp_val=0 and resp_result=0 immediately; after release, MUL 2x2 -> 4 with normal latency.
- Macro on: MUL 6x0 -> 0 after 1 CALC cycle; MUL 6x1 -> 6 after 2 CALC cycles; p_nbits=8 MULHU 0xFF x 0xFF -> 0xFE.
